set_assoc_cache_ctrl: RTL and testbench
=======================================

SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter INDEX_W, default 8, set-index width (2**INDEX_W sets).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2); OFF_W = log2(LINE_WORDS)+2, TAG_W = ADDR_W-INDEX_W-OFF_W.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-005 Ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-006 Ports: cpu_req_valid in 1 request; cpu_req_ready out 1 controller can accept; cpu_req_rw in 1 (1=write, 0=read); cpu_req_addr in ADDR_W; cpu_req_wdata in 32.
REQ-007 Ports: cpu_resp_valid out 1 completion pulse; cpu_resp_rdata out 32 read word.
REQ-008 Ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_rw out 1 (1=write-back); mem_req_addr out ADDR_W line-aligned; mem_req_wdata out 32*LINE_WORDS.
REQ-009 Ports: mem_resp_valid in 1 fill-data strobe; mem_resp_rdata in 32*LINE_WORDS; hit_count out 32; miss_count out 32.

Function
REQ-010 SHALL implement a 2-way set-associative, write-back, write-allocate cache; per way per set: valid, dirty, tag, line; per set: one LRU bit (way to replace next).
REQ-011 Address split: offset [OFF_W-1:0] (word select [OFF_W-1:2], byte bits ignored), index [OFF_W+INDEX_W-1:OFF_W], tag = upper TAG_W bits.
REQ-012 States: IDLE, LOOKUP, WB_REQ, RD_REQ, RD_WAIT.
REQ-013 IDLE: cpu_req_ready=1; on cpu_req_valid register addr/rw/wdata, go LOOKUP; requests are never accepted outside IDLE.
REQ-014 LOOKUP hit (valid && tag match in either way): read -> cpu_resp_rdata = selected word; write -> merge word into line, set dirty; cpu_resp_valid=1 for exactly one cycle; LRU := other way; hit_count++; go IDLE.
REQ-015 Hit latency: request accepted at edge N, cpu_resp_valid high in cycle N+2 (registered), ready again same cycle.
REQ-016 LOOKUP miss: victim = first invalid way (way 0 before way 1), else LRU way; miss_count++; go WB_REQ if victim valid && dirty, else RD_REQ.
REQ-017 WB_REQ: mem_req_valid=1, rw=1, addr={victim tag, index, 0}, wdata=victim line; all held stable until mem_req_ready sampled high; then clear victim dirty, go RD_REQ.
REQ-018 RD_REQ: mem_req_valid=1, rw=0, addr={req tag, index, 0} held until mem_req_ready; then RD_WAIT.
REQ-019 RD_WAIT: on mem_resp_valid write mem_resp_rdata into victim way, valid=1, dirty=0, tag=req tag; go LOOKUP (guaranteed hit, completes per REQ-014; miss_count not incremented again, hit_count not incremented on this replay).
REQ-020 mem_resp_valid outside RD_WAIT SHALL be ignored; mem_req_valid SHALL be 0 in IDLE, LOOKUP, RD_WAIT.
REQ-021 hit_count/miss_count SHALL saturate at 32'hFFFF_FFFF (no wrap).
REQ-022 Same-cycle mem_req_ready and state entry: handshake completes only on a cycle where mem_req_valid is already 1 (registered output).

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, all valid/dirty/LRU bits 0, counters 0, cpu_req_ready 0, cpu_resp_valid 0, cpu_resp_rdata 0, mem_req_valid 0, mem_req_rw 0, mem_req_addr 0, mem_req_wdata 0; tag/data arrays not reset.
REQ-024 First cycle after rst_n release: cpu_req_ready=1; reset mid-transaction abandons it, no response, no memory request in flight.

Verification (defaults; index=addr[11:4], tag=addr[31:12])
REQ-025 Cold read 0x0000_1230, fill line word[3]=0xDEADBEEF -> one RD_REQ addr 0x0000_1230, resp 0xDEADBEEF, miss_count=1, hit_count=0.
REQ-026 Repeat read 0x0000_123C -> no mem request, response cycle N+2, hit_count=1.
REQ-027 Write 0x0000_5230 data 0x1111_2222 (miss, way1 alloc), then read 0x0000_9230 (set full, LRU=way0 clean) -> way0 replaced, no write-back.
REQ-028 Then read 0x0000_D230 (LRU=way1 dirty) -> WB_REQ addr 0x0000_5230 wdata word0=0x1111_2222, then RD_REQ 0x0000_D230.
REQ-029 Hold mem_req_ready=0 for 10 cycles during WB_REQ -> mem_req_valid/addr/wdata stable; assert rst_n=0 mid-wait -> all outputs to REQ-023 values immediately.
REQ-030 Force miss_count to 32'hFFFF_FFFF then miss -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative, write-back / write-allocate cache controller.
// One request in flight; misses write back a dirty victim, then fill and replay the lookup.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic                       cpu_req_rw,
  input  logic [ADDR_W-1:0]          cpu_req_addr,
  input  logic [31:0]                cpu_req_wdata,
  output logic                       cpu_resp_valid,
  output logic [31:0]                cpu_resp_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rw,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [32*LINE_WORDS-1:0]   mem_req_wdata,
  input  logic                       mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0]   mem_resp_rdata,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB_REQ, S_RD_REQ, S_RD_WAIT} state_t;
  state_t state, state_nxt;

  logic [LINE_W-1:0]      data_q [2][SETS];
  logic [TAG_W-1:0]       tag_q  [2][SETS];
  logic [SETS-1:0][1:0]   valid_q, dirty_q;
  logic [SETS-1:0]        lru_q;

  logic [ADDR_W-1:0] req_addr_q;
  logic              req_rw_q;
  logic [31:0]       req_wdata_q;
  logic              victim_q, replay_q;
  logic [31:0]       hit_cnt, miss_cnt;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  wsel;
  logic               unused_byte;
  assign idx         = req_addr_q[OFF_W +: INDEX_W];
  assign tag         = req_addr_q[ADDR_W-1 -: TAG_W];
  assign wsel        = req_addr_q[2 +: WSEL_W];
  assign unused_byte = ^req_addr_q[1:0];

  logic              hit0, hit1, hit, hit_way, victim_c, vic_dirty;
  logic [LINE_W-1:0] hit_line, merged;
  logic [31:0]       hit_word;

  always_comb begin
    hit0      = valid_q[idx][0] && (tag_q[0][idx] == tag);
    hit1      = valid_q[idx][1] && (tag_q[1][idx] == tag);
    hit       = hit0 || hit1;
    hit_way   = !hit0 && hit1;
    // fill invalid ways in order before evicting anything
    victim_c  = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);
    vic_dirty = valid_q[idx][victim_c] && dirty_q[idx][victim_c];
    hit_line  = hit_way ? data_q[1][idx] : data_q[0][idx];
    hit_word  = '0;
    merged    = hit_line;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (wsel == WSEL_W'(w)) begin
        hit_word          = hit_line[w*32 +: 32];
        merged[w*32 +: 32] = req_wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cpu_req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP:  state_nxt = hit ? S_IDLE : (vic_dirty ? S_WB_REQ : S_RD_REQ);
      S_WB_REQ:  if (mem_req_valid && mem_req_ready) state_nxt = S_RD_REQ;
      S_RD_REQ:  if (mem_req_valid && mem_req_ready) state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_resp_valid) state_nxt = S_LOOKUP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      lru_q          <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      req_addr_q     <= '0;
      req_rw_q       <= 1'b0;
      req_wdata_q    <= '0;
      victim_q       <= 1'b0;
      replay_q       <= 1'b0;
    end else begin
      cpu_resp_valid <= 1'b0;
      cpu_req_ready  <= (state_nxt == S_IDLE);
      case (state)
        S_IDLE: if (cpu_req_valid) begin
          req_addr_q  <= cpu_req_addr;
          req_rw_q    <= cpu_req_rw;
          req_wdata_q <= cpu_req_wdata;
          replay_q    <= 1'b0;
        end
        S_LOOKUP: if (hit) begin
          cpu_resp_valid <= 1'b1;
          cpu_resp_rdata <= hit_word;
          lru_q[idx]     <= ~hit_way;
          if (req_rw_q) dirty_q[idx][hit_way] <= 1'b1;
          // the post-fill replay was already counted as a miss
          if (!replay_q && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
          victim_q      <= victim_c;
          mem_req_valid <= 1'b1;
          if (vic_dirty) begin
            mem_req_rw    <= 1'b1;
            mem_req_addr  <= {tag_q[victim_c][idx], idx, {OFF_W{1'b0}}};
            mem_req_wdata <= data_q[victim_c][idx];
          end else begin
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        S_WB_REQ: if (mem_req_ready) begin
          dirty_q[idx][victim_q] <= 1'b0;
          mem_req_rw             <= 1'b0;
          mem_req_addr           <= {tag, idx, {OFF_W{1'b0}}};
        end
        S_RD_REQ: if (mem_req_ready) mem_req_valid <= 1'b0;
        S_RD_WAIT: if (mem_resp_valid) begin
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= 1'b0;
          replay_q               <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // tag/data storage carries no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_rw_q)
      data_q[hit_way][idx] <= merged;
    if (state == S_RD_WAIT && mem_resp_valid) begin
      data_q[victim_q][idx] <= mem_resp_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: fills, hits, LRU replacement, write-back, saturation, reset.
module tb_set_assoc_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid, cpu_req_ready, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [31:0]  hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  set_assoc_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called at a negedge with the controller idle
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    chk("req_ready", {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_mem();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin ok = 1; break; end
    end
    if (!ok) chk("mem_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(output logic [31:0] d);
    bit ok = 0;
    d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin ok = 1; d = cpu_resp_rdata; break; end
    end
    if (!ok) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  task automatic fill(input logic [127:0] line);
    mem_resp_valid = 1'b1; mem_resp_rdata = line;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
  endtask

  task automatic hold_check(input logic [31:0] a, input logic [127:0] wd);
    bit stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!mem_req_valid || mem_req_addr !== a || mem_req_wdata !== wd || !mem_req_rw) stable = 0;
    end
    chk("wb_hold_stable", {31'd0, stable}, 32'd1);
  endtask

  logic [31:0]  d;
  logic [127:0] wb_line;

  initial begin
    rst_n = 1'b0; cpu_req_valid = 0; cpu_req_rw = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    #12;
    chk("rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cpu_req_ready}, 32'd1);

    // cold read miss, fill, replay hit
    do_req(1'b0, 32'h0000_1230, '0);
    wait_mem();
    chk("cold_rd_rw", {31'd0, mem_req_rw}, 32'd0);
    chk("cold_rd_addr", mem_req_addr, 32'h0000_1230);
    handshake();
    fill({32'hDEAD_BEEF, 32'h1313_1313, 32'h1212_1212, 32'hDEAD_BEEF});
    wait_resp(d);
    chk("cold_rdata", d, 32'hDEAD_BEEF);
    chk("cold_miss", miss_count, 32'd1);
    chk("cold_hit", hit_count, 32'd0);

    // hit: response exactly one cycle after the LOOKUP cycle
    do_req(1'b0, 32'h0000_123C, '0);
    @(negedge clk);
    chk("hit_resp_valid", {31'd0, cpu_resp_valid}, 32'd1);
    chk("hit_rdata", cpu_resp_rdata, 32'hDEAD_BEEF);
    chk("hit_no_mem", {31'd0, mem_req_valid}, 32'd0);
    chk("hit_count1", hit_count, 32'd1);
    @(negedge clk);
    chk("hit_pulse_once", {31'd0, cpu_resp_valid}, 32'd0);
    do_req(1'b0, 32'h0000_1234, '0);
    wait_resp(d);
    chk("hit_word1", d, 32'h1212_1212);

    // write miss allocates way1
    do_req(1'b1, 32'h0000_5230, 32'h1111_2222);
    wait_mem();
    chk("wr_miss_rw", {31'd0, mem_req_rw}, 32'd0);
    chk("wr_miss_addr", mem_req_addr, 32'h0000_5230);
    handshake();
    fill({32'h5353_5353, 32'h5252_5252, 32'h5151_5151, 32'h5050_5050});
    wait_resp(d);
    chk("wr_miss_count", miss_count, 32'd2);

    // LRU way0 is clean: straight to read, no write-back
    do_req(1'b0, 32'h0000_9230, '0);
    wait_mem();
    chk("clean_evict_rw", {31'd0, mem_req_rw}, 32'd0);
    chk("clean_evict_addr", mem_req_addr, 32'h0000_9230);
    handshake();
    fill({32'h9393_9393, 32'h9292_9292, 32'h9191_9191, 32'h9090_9090});
    wait_resp(d);
    chk("clean_evict_rdata", d, 32'h9090_9090);

    // LRU way1 is dirty: write-back held under backpressure, then read
    do_req(1'b0, 32'h0000_D230, '0);
    wait_mem();
    chk("wb_rw", {31'd0, mem_req_rw}, 32'd1);
    chk("wb_addr", mem_req_addr, 32'h0000_5230);
    wb_line = mem_req_wdata;
    chk("wb_word0", wb_line[31:0], 32'h1111_2222);
    chk("wb_word1", wb_line[63:32], 32'h5151_5151);
    hold_check(32'h0000_5230, wb_line);
    handshake();
    chk("rd_after_wb_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("rd_after_wb_rw", {31'd0, mem_req_rw}, 32'd0);
    chk("rd_after_wb_addr", mem_req_addr, 32'h0000_D230);
    handshake();
    fill({32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0});
    wait_resp(d);
    chk("wb_fill_rdata", d, 32'hD0D0_D0D0);
    chk("miss_count4", miss_count, 32'd4);
    chk("hit_count2", hit_count, 32'd2);

    // dirty both ways; LRU ends on way1 (D230)
    do_req(1'b1, 32'h0000_D230, 32'h0000_AAAA);
    wait_resp(d);
    do_req(1'b1, 32'h0000_9230, 32'h0000_BBBB);
    wait_resp(d);
    chk("hit_count4", hit_count, 32'd4);

    // saturated miss counter, then reset during a stalled write-back
    force dut.miss_cnt = 32'hFFFF_FFFF;
    #1 release dut.miss_cnt;
    do_req(1'b0, 32'h0000_1230, '0);
    wait_mem();
    chk("sat_miss", miss_count, 32'hFFFF_FFFF);
    chk("wb2_addr", mem_req_addr, 32'h0000_D230);
    wb_line = mem_req_wdata;
    chk("wb2_word0", wb_line[31:0], 32'h0000_AAAA);
    hold_check(32'h0000_D230, wb_line);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    chk("mid_rst_resp", {31'd0, cpu_resp_valid}, 32'd0);
    chk("mid_rst_rdata", cpu_resp_rdata, 32'd0);
    chk("mid_rst_mvalid", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_rst_mrw", {31'd0, mem_req_rw}, 32'd0);
    chk("mid_rst_maddr", mem_req_addr, 32'd0);
    chk("mid_rst_mwdata", mem_req_wdata[31:0], 32'd0);
    chk("mid_rst_hit", hit_count, 32'd0);
    chk("mid_rst_miss", miss_count, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, cpu_req_ready}, 32'd1);
    @(negedge clk);
    chk("rel_no_mem", {31'd0, mem_req_valid}, 32'd0);
    chk("rel_no_resp", {31'd0, cpu_resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
